// File: rtl/datamem_pkg.sv
// Shared types and constants for the byte-addressed data memory.
// Provides access-size encodings, the default depth and access decoding helpers.
package datamem_pkg;

  localparam int DEPTH_BYTES_DEFAULT = 1024;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef logic [63:0] word_t;

  // An access is legal only for a supported size with natural alignment.
  function automatic logic access_valid(input logic [3:0] size, input logic [2:0] addr_lo);
    logic ok;
    ok = 1'b0;
    unique case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0]   == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      SZ_D:    ok = (addr_lo      == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an access of the given size, lane 0 at the base address.
  function automatic logic [7:0] byte_mask(input logic [3:0] size);
    logic [7:0] m;
    m = 8'h00;
    unique case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mux64_2x1.sv
// 64-bit two-input selector used to pick forwarded store data.
// out follows A when sel is high, B otherwise.
module mux64_2x1
  import datamem_pkg::*;
(
  input  logic  sel,
  input  word_t A,
  input  word_t B,
  output word_t out
);

  assign out = sel ? A : B;

endmodule

// File: rtl/datamem.sv
// Byte-addressed little-endian data memory with combinational loads and clocked stores.
// Define DATAMEM_STORE_FWD_EN to let forward_sel choose fwd_data as the store source.
module datamem
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [3:0]  xfer_size,
  input  logic [63:0] store_data,
  input  logic [63:0] fwd_data,
  input  logic        forward_sel,
  output logic [63:0] read_data
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  typedef logic [IDX_W-1:0] idx_t;

  logic [7:0] mem [DEPTH_BYTES];
  word_t      wdata;
  idx_t       idx;
  logic       valid;
  logic [7:0] lanes;

  // Upper address bits fall away here, which is what makes accesses wrap.
  assign idx   = address[IDX_W-1:0];
  assign valid = access_valid(xfer_size, address[2:0]);
  assign lanes = byte_mask(xfer_size);

`ifdef DATAMEM_STORE_FWD_EN
  mux64_2x1 u_store_sel (
    .sel (forward_sel),
    .A   (fwd_data),
    .B   (store_data),
    .out (wdata)
  );
`else
  logic unused_fwd;
  assign wdata      = store_data;
  assign unused_fwd = ^{fwd_data, forward_sel};
`endif

  logic unused_addr;
  assign unused_addr = ^address[63:IDX_W];

  // NOTE: the memory must be cleared by reset, so it is a register array rather
  // than an inferred RAM; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (write_enable && valid) begin
      // Aligned accesses never cross the end of the array, so idx+i cannot wrap.
      for (int i = 0; i < 8; i++) begin
        if (lanes[i]) begin
          mem[idx + idx_t'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // NOTE: default assignment first so the combinational load never infers a latch.
  always_comb begin
    read_data = '0;
    if (read_enable && valid) begin
      for (int i = 0; i < 8; i++) begin
        if (lanes[i]) begin
          read_data[8*i +: 8] = mem[idx + idx_t'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_datamem.sv
// Self-checking bench for datamem: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_datamem;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [3:0]  xfer_size;
  logic [63:0] store_data;
  logic [63:0] fwd_data;
  logic        forward_sel;
  logic [63:0] read_data;

  int checks = 0;
  int errors = 0;

  byte unsigned model_mem [DEPTH];

  datamem #(.DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .xfer_size    (xfer_size),
    .store_data   (store_data),
    .fwd_data     (fwd_data),
    .forward_sel  (forward_sel),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit legal(longint unsigned addr, int size);
    return (size == 1 || size == 2 || size == 4 || size == 8) && (addr % longint'(size) == 0);
  endfunction

  function automatic logic [63:0] model_load(longint unsigned addr, int size, bit re);
    logic [63:0] r;
    longint unsigned base;
    r = 64'd0;
    if (re && legal(addr, size)) begin
      base = addr % DEPTH;
      for (int i = 0; i < size; i++) begin
        r = r + (64'(model_mem[base + longint'(i)]) << (8 * i));
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] addr, input int size, input bit we, input bit re,
                       input logic [63:0] sd, input logic [63:0] fd, input bit fs);
    address      = addr;
    xfer_size    = 4'(size);
    write_enable = we;
    read_enable  = re;
    store_data   = sd;
    fwd_data     = fd;
    forward_sel  = fs;
    #1;
  endtask

  // Apply the edge to the model using the inputs currently driven, then clock the DUT.
  task automatic step();
    logic [63:0] eff;
    longint unsigned base;
`ifdef DATAMEM_STORE_FWD_EN
    eff = forward_sel ? fwd_data : store_data;
`else
    eff = store_data;
`endif
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    end else if (write_enable && legal(address, int'(xfer_size))) begin
      base = address % DEPTH;
      for (int i = 0; i < int'(xfer_size); i++) begin
        model_mem[base + longint'(i)] = 8'((eff >> (8 * i)) & 64'hFF);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_check(input string tag, input logic [63:0] addr, input int size, input bit re);
    drive(addr, size, 1'b0, re, 64'd0, 64'd0, 1'b0);
    check(tag, read_data, model_load(addr, size, re));
  endtask

  task automatic store(input logic [63:0] addr, input int size, input logic [63:0] sd);
    drive(addr, size, 1'b1, 1'b0, sd, 64'd0, 1'b0);
    step();
  endtask

  initial begin
    logic [63:0] a, sd, fd;
    int sz, pick;
    bit we, re, fs;

    reset = 1'b1;
    drive(64'd0, 8, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    step();
    reset = 1'b0;
    load_check("reset_zero", 64'd0, 8, 1'b1);
    check("reset_zero_const", read_data, 64'd0);

    // Doubleword store with simultaneous load: old data before, new after.
    drive(64'd128, 8, 1'b1, 1'b1, 64'd69, 64'd0, 1'b0);
    check("dw_before_edge", read_data, 64'd0);
    step();
    check("dw_after_edge", read_data, 64'd69);

    // Forwarded store source.
    drive(64'd64, 8, 1'b1, 1'b0, 64'd5, 64'hDEADBEEF, 1'b1);
    step();
    drive(64'd64, 8, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
`ifdef DATAMEM_STORE_FWD_EN
    check("fwd_store", read_data, 64'hDEADBEEF);
`else
    check("fwd_store", read_data, 64'd5);
`endif

    // Partial widths.
    store(64'd0, 8, 64'h1122334455667788);
    store(64'd2, 1, 64'h00000000000000FF);
    drive(64'd0, 8, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("partial_d0", read_data, 64'h1122334455FF7788);
    drive(64'd6, 2, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("partial_h6", read_data, 64'h1122);
    drive(64'd4, 4, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("partial_w4", read_data, 64'h11223344);

    // Invalid stores leave memory alone; invalid loads return zero.
    store(64'd6, 4, 64'hAAAAAAAAAAAAAAAA);
    store(64'd0, 3, 64'hBBBBBBBBBBBBBBBB);
    drive(64'd0, 8, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("invalid_unchanged", read_data, 64'h1122334455FF7788);
    drive(64'd6, 4, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("invalid_load_misal", read_data, 64'd0);
    drive(64'd0, 3, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("invalid_load_size3", read_data, 64'd0);

    // Wrap-around and read gating.
    store(64'(DEPTH + 8), 8, 64'd7);
    drive(64'd8, 8, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("wrap_load", read_data, 64'd7);
    drive(64'd8, 8, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    check("read_gated", read_data, 64'd0);

    // Reset beats a simultaneous store; loads during reset see current contents.
    reset = 1'b1;
    drive(64'd8, 8, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
    check("load_during_reset", read_data, 64'd7);
    drive(64'd16, 8, 1'b1, 1'b1, 64'd9, 64'd0, 1'b0);
    step();
    reset = 1'b0;
    load_check("reset_priority", 64'd16, 8, 1'b1);
    check("reset_priority_const", read_data, 64'd0);
    load_check("reset_cleared", 64'd8, 8, 1'b1);

    // Randomized traffic over a small window, with random high address bits.
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 9));
      sz   = (pick < 2) ? 1 : (pick < 4) ? 2 : (pick < 6) ? 4 : (pick < 9) ? 8 : int'($urandom_range(0, 15));
      a    = {$urandom(), $urandom()};
      a    = (a & ~64'(DEPTH - 1)) | 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz != 0) a = a & ~64'(sz - 1);
      sd   = {$urandom(), $urandom()};
      fd   = {$urandom(), $urandom()};
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 3) != 0);
      fs   = 1'($urandom_range(0, 1));
      drive(a, sz, we, re, sd, fd, fs);
      check("rand_before_edge", read_data, model_load(a, sz, re));
      step();
      check("rand_after_edge", read_data, model_load(a, sz, re));
    end

    for (int k = 0; k < 64; k += 8) begin
      load_check("final_sweep", 64'(k), 8, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
